// File: rtl/mod_instruction_fetch_if.sv
// mod_instruction_fetch_if: ROM, redirect and IF-stage handshake signals of the fetch unit
interface mod_instruction_fetch_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] instruction;
  logic              mem_end;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  modport master (
    output address, if_valid, if_instr, if_pc,
    input  instruction, mem_end, redirect_valid, redirect_addr, if_ready
  );
  modport slave (
    input  address, if_valid, if_instr, if_pc,
    output instruction, mem_end, redirect_valid, redirect_addr, if_ready
  );
endinterface

// File: rtl/mod_instruction_fetch.sv
// mod_instruction_fetch: PC, ROM addressing and registered IF stage with redirect and halt
module mod_instruction_fetch #(
  parameter int                ADDR_W   = 30,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  mod_instruction_fetch_if.master bus,
  output logic                 halted,
  output logic [CNT_W-1:0]     fetch_count
);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              valid_n, cap, slot_free, xfer;
  assign slot_free   = !bus.if_valid || bus.if_ready;
  assign xfer        = bus.if_valid && bus.if_ready;
  assign bus.address = pc;
  assign halted      = state == HALT;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = bus.if_valid;
    cap     = 1'b0;
    if (state == IDLE) state_n = start ? FETCH : IDLE;
    else if (bus.redirect_valid) begin
      pc_n    = bus.redirect_addr;
      valid_n = 1'b0;
      state_n = FETCH;
    end else if (state == FETCH && slot_free) begin
      // end of program only takes effect once the slot can accept a new word
      valid_n = !bus.mem_end;
      state_n = bus.mem_end ? HALT : FETCH;
      cap     = !bus.mem_end;
      pc_n    = bus.mem_end ? pc : pc + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      bus.if_valid <= 1'b0;
      bus.if_instr <= '0;
      bus.if_pc    <= '0;
      fetch_count  <= '0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      bus.if_valid <= valid_n;
      if (cap) begin
        bus.if_instr <= bus.instruction;
        bus.if_pc    <= pc;
      end
      if (xfer && !(&fetch_count)) fetch_count <= fetch_count + 1'b1;
    end
  end
endmodule

// File: doc/mod_instruction_fetch.md
Name: mod_instruction_fetch

Overview:
Instruction fetch unit that drives the word address into the combinational instruction ROM (mod_instruction_mem_rom) and consumes its instruction and mem_end outputs. Holds the program counter and registers each fetched word into an IF output stage with a valid/ready handshake toward decode. Accepts a redirect (jump/branch target) from downstream. Halts when the ROM flags end of program.

Parameters:
ADDR_W, 30, word-address width (PC width); matches the ROM address port
DATA_W, 32, instruction width
RESET_PC, 0, PC value after reset
CNT_W, 16, width of the fetched-instruction counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse; leaves IDLE and begins fetching
address  output  ADDR_W  word address to ROM; always equals the PC register
instruction  input  DATA_W  ROM read data, combinational from address
mem_end  input  1  ROM end-of-program flag for the current address
redirect_valid  input  1  load PC from redirect_addr and flush the IF stage
redirect_addr  input  ADDR_W  redirect target word address
if_valid  output  1  IF stage holds a valid instruction
if_ready  input  1  decode accepts the IF stage this cycle
if_instr  output  DATA_W  fetched instruction
if_pc  output  ADDR_W  word address of if_instr
halted  output  1  high while in HALT
fetch_count  output  CNT_W  instructions accepted by decode; saturating

Behaviour:
- Reset (rst=1 at edge): PC=RESET_PC, state=IDLE, if_valid=0, if_instr=0, if_pc=0, halted=0, fetch_count=0. Applies mid-operation and overrides all other inputs. A new start pulse is required after reset.
- States: IDLE, FETCH, HALT.
- IDLE: start moves to FETCH; redirect_valid is ignored; the PC does not change.
- slot_free = !if_valid || if_ready.
- FETCH, priority order:
  1. redirect_valid: PC<=redirect_addr; if_valid<=0; no capture; stay in FETCH.
  2. slot_free && mem_end: no capture; if_valid<=0; move to HALT; PC holds.
  3. slot_free: if_instr<=instruction; if_pc<=PC; if_valid<=1; PC<=PC+1, wrapping modulo 2^ADDR_W.
  4. Otherwise (stalled): PC, if_instr, if_pc and if_valid hold; address is stable.
- HALT: halted=1 and if_valid=0. redirect_valid causes PC<=redirect_addr, halted<=0 and a move to FETCH. start is ignored.
- Handshake:
  - A beat transfers when if_valid && if_ready.
  - if_instr and if_pc are stable while if_valid && !if_ready.
  - Full throughput: one instruction per cycle when if_ready stays high.
- Latency:
  - start sampled at edge N; FETCH is active during cycle N+1; capture at edge N+1.
  - if_valid is first high in cycle N+2 with if_pc=RESET_PC.
- fetch_count increments on every transfer, including a transfer in the same cycle as redirect or mem_end. It saturates at 2^CNT_W-1.
- redirect_valid in the same cycle as a transfer: the beat counts as accepted and the next beat comes from redirect_addr.
- The ROM returns 0 beyond its range. mem_end is the only end indicator, and zero words are never treated as end of program.

Test Plan:
1. Reset, start pulse at edge N, if_ready=1 -> if_valid high from cycle N+2; if_instr/if_pc sequence 0x04000001/0, 0x04010002/1, ... with one word per cycle and no bubbles.
2. Hold if_ready=0 while if_pc=3 -> if_instr stays 0x04030004, address stays 4, fetch_count stays 3 for all stall cycles. Releasing if_ready -> next beat is pc 4.
3. Free-run to the end -> last beat 0x0BFFFFFE at if_pc=34; address=35 with mem_end=1 -> halted=1 next cycle, if_valid=0, fetch_count=35, address stays 35.
4. Assert redirect_valid with redirect_addr=32 while if_valid=1 at if_pc=5 and if_ready=0 -> next cycle if_valid=0 and address=32. Following cycle if_instr=0x00400820 with if_pc=32. The pc-5 word is never counted.
5. From HALT, redirect to 0 -> halted drops next cycle; 0x04000001 is refetched; fetch_count continues from 35.
6. Assert rst mid-stream at if_pc=10 -> next cycle all outputs are at reset values and address=0. A start pulse is needed to resume.
